div_ctrl: RTL and testbench

Multi-cycle integer divide controller for the execute stage of the 5-stage MIPS pipeline. It accepts a DIV/DIVU request from E and sequences a 32-iteration radix-2 restoring divide, handling sign correction and divide-by-zero. It produces the `div_stall` signal consumed by the hazard unit as `div_stallE`, and delivers the 64-bit {HI, LO} result for the HI/LO write path. An exception flush from M cancels an in-flight divide.

---
 rtl/div_ctrl.sv | 137 +++++++++++++
 tb/tb_div_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : div_ctrl
// Brief    : Multi-cycle radix-2 restoring DIV/DIVU controller for the E stage.
// Revision : 1.0
// ============================================================================
module div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 signed_div,
    input  logic [WIDTH-1:0]     opdata1,
    input  logic [WIDTH-1:0]     opdata2,
    input  logic                 annul,
    output logic [2*WIDTH-1:0]   result,
    output logic                 ready,
    output logic                 div_stall
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DIVZERO = 2'd1,
        S_ON      = 2'd2,
        S_END     = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH:0]    work_q, work_d;
    logic [WIDTH-1:0]    divisor_q, divisor_d;
    logic                qsign_q, qsign_d;
    logic                rsign_q, rsign_d;
    logic [2*WIDTH-1:0]  result_q, result_d;
    logic                ready_q, ready_d;

    logic                op1_neg, op2_neg;
    logic [WIDTH-1:0]    abs1, abs2;
    logic [WIDTH+1:0]    rem_sh, trial;
    logic                borrow;
    logic [WIDTH-1:0]    quo_fin, rem_fin;

    assign op1_neg = signed_div & opdata1[WIDTH-1];
    assign op2_neg = signed_div & opdata2[WIDTH-1];
    assign abs1    = op1_neg ? -opdata1 : opdata1;
    assign abs2    = op2_neg ? -opdata2 : opdata2;

    // Shifted remainder carries one spare top bit so the trial subtract exposes its borrow.
    assign rem_sh  = work_q[2*WIDTH:WIDTH-1];
    assign trial   = rem_sh - {2'b00, divisor_q};
    assign borrow  = trial[WIDTH+1];
    assign quo_fin = {work_q[WIDTH-2:0], ~borrow};
    assign rem_fin = borrow ? work_q[2*WIDTH-2:WIDTH-1] : trial[WIDTH-1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        qsign_d   = qsign_q;
        rsign_d   = rsign_q;
        result_d  = result_q;
        ready_d   = 1'b0;

        if (annul) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        divisor_d = abs2;
                        work_d    = {{(WIDTH+1){1'b0}}, abs1};
                        qsign_d   = op1_neg ^ op2_neg;
                        rsign_d   = op1_neg;
                        cnt_d     = '0;
                        state_d   = (opdata2 == '0) ? S_DIVZERO : S_ON;
                    end
                end
                S_DIVZERO: begin
                    result_d = '0;
                    ready_d  = 1'b1;
                    state_d  = S_END;
                end
                S_ON: begin
                    work_d = borrow ? {work_q[2*WIDTH-1:0], 1'b0}
                                    : {trial[WIDTH:0], work_q[WIDTH-2:0], 1'b1};
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == LAST_CNT) begin
                        result_d = {rsign_q ? -rem_fin : rem_fin,
                                    qsign_q ? -quo_fin : quo_fin};
                        ready_d  = 1'b1;
                        state_d  = S_END;
                    end
                end
                S_END: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            work_q    <= '0;
            divisor_q <= '0;
            qsign_q   <= 1'b0;
            rsign_q   <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            qsign_q   <= qsign_d;
            rsign_q   <= rsign_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result    = result_q;
    assign ready     = ready_q;
    assign div_stall = start & ~ready_q;

endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_ctrl
// Brief    : Scoreboard bench for div_ctrl against an arithmetic reference.
// Revision : 1.0
// ============================================================================
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        signed_div = 1'b0;
    logic        annul = 1'b0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic [63:0] result;
    logic        ready;
    logic        div_stall;

    div_ctrl #(.WIDTH(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .signed_div (signed_div),
        .opdata1    (op1),
        .opdata2    (op2),
        .annul      (annul),
        .result     (result),
        .ready      (ready),
        .div_stall  (div_stall)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] res;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] last_res = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer division with truncation toward zero.
    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sd, q, r;
        if (b == 32'h0) return 64'h0;
        if (s) begin
            sa = longint'($signed(a));
            sd = longint'($signed(b));
        end else begin
            sa = {32'h0, a};
            sd = {32'h0, b};
        end
        q = sa / sd;
        r = sa % sd;
        return {r[31:0], q[31:0]};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (resetn && ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got ready=1 with result %h, expected ready=0 (cycle %0d)", result, cyc);
            end else begin
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("ready_cycle", 64'(cyc), 64'(e.cyc));
                last_res = e.res;
            end
        end
    end

    // Issue at a negedge; returns at the negedge after the ready cycle.
    task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b, input bit hold);
        int   lat;
        exp_t e;
        start      = 1'b1;
        signed_div = s;
        op1        = a;
        op2        = b;
        lat        = (b == 32'h0) ? 2 : 33;
        e.res      = model(s, a, b);
        e.cyc      = cyc + lat;
        sb.push_back(e);
        for (int k = 0; k <= lat; k++) begin
            #1 chk("div_stall", {63'h0, div_stall}, {63'h0, (k < lat)});
            if (k == lat) break;
            @(negedge clk);
            op1        = $urandom;
            op2        = $urandom;
            signed_div = 1'($urandom);
        end
        if (!hold) start = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_annul();
        start      = 1'b1;
        signed_div = 1'b0;
        op1        = 32'hFFFFFFFF;
        op2        = 32'd3;
        repeat (11) @(negedge clk);
        annul = 1'b1;
        repeat (3) @(negedge clk);
        annul = 1'b0;
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1 chk("annul_result_hold", result, last_res);
            chk("annul_no_ready", {63'h0, ready}, 64'h0);
            @(negedge clk);
        end
    endtask

    task automatic do_reset_mid();
        start      = 1'b1;
        signed_div = 1'b1;
        op1        = 32'd1000;
        op2        = 32'd10;
        repeat (16) @(negedge clk);
        #2 resetn = 1'b0;
        #1 chk("rst_mid_result", result, 64'h0);
        chk("rst_mid_ready", {63'h0, ready}, 64'h0);
        chk("rst_mid_stall", {63'h0, div_stall}, {63'h0, start});
        last_res = '0;
        start = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic        s;
        logic [31:0] a, b;
        bit          h;

        start = 1'b1;
        #1 chk("reset_result", result, 64'h0);
        chk("reset_ready", {63'h0, ready}, 64'h0);
        chk("reset_stall", {63'h0, div_stall}, 64'h1);
        start = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        do_div(1'b0, 32'd100, 32'd7, 1'b0);
        do_div(1'b1, 32'hFFFFFFF9, 32'd2, 1'b0);
        do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        do_div(1'b0, 32'd5, 32'd0, 1'b0);
        do_annul();
        do_div(1'b0, 32'd9, 32'd3, 1'b0);
        do_div(1'b0, 32'd20, 32'd6, 1'b1);
        do_div(1'b1, 32'hFFFFFFEC, 32'd6, 1'b0);
        do_reset_mid();
        do_div(1'b1, 32'd1000, 32'd10, 1'b0);
        do_div(1'b1, 32'd7, 32'd0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom);
            a = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'h0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFFFFFF;
                3:       b = -($urandom_range(1, 100));
                default: b = $urandom;
            endcase
            h = (i != 23) ? bit'($urandom) : 1'b0;
            do_div(s, a, b, h);
        end

        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
